// File: rtl/pipeline_pkg.sv
// Shared types and constants for the 5-stage core pipeline.
package pipeline_pkg;

  localparam int          PC_W_DEF    = 32;
  localparam int          INSTR_W_DEF = 32;
  localparam int          PC_INCR     = 4;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DROP  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/if_fetch_stage_skid.sv
// if_skid_buffer: single-entry {pc, instr} holding register; clear wins over load.
module if_skid_buffer #(
  parameter int PC_W    = 32,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               arst_n,
  input  logic               load,
  input  logic               clear,
  input  logic [PC_W-1:0]    ld_pc,
  input  logic [INSTR_W-1:0] ld_instr,
  output logic [PC_W-1:0]    pc,
  output logic [INSTR_W-1:0] instr,
  output logic               full
);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      pc    <= '0;
      instr <= '0;
      full  <= 1'b0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (load) begin
      pc    <= ld_pc;
      instr <= ld_instr;
      full  <= 1'b1;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// IF stage: PC register, imem request handshake and IF/ID register with stall/redirect handling.
// Optional stall/flush counters are built when IF_PERF_CNT_EN is defined.
//
// state | meaning
// IDLE  | no request on the bus; waits for enable
// FETCH | request at pc_q on the bus until imem_ready
// HOLD  | response parked in skid buffer while the hazard stall is active
// DROP  | redirected while a request was pending; waiting to discard its response
module if_fetch_stage #(
  parameter int                 PC_W      = pipeline_pkg::PC_W_DEF,
  parameter int                 INSTR_W   = pipeline_pkg::INSTR_W_DEF,
  parameter logic [PC_W-1:0]    PC_RESET  = '0,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(pipeline_pkg::NOP_INSTR)
) (
  input  logic               clk,
  input  logic               arst_n,
  input  logic               enable,
  input  logic               prevent_update_pc,
  input  logic               prevent_update_reg_IF_ID,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  input  logic               jump,
  input  logic [PC_W-1:0]    jump_target,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [PC_W-1:0]    if_id_pc,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic               if_id_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]        stall_cycles,
  output logic [31:0]        flush_count
`endif
);

  import pipeline_pkg::*;

  fetch_state_t       state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d, drop_addr_q, pc_next, redirect_pc;
  logic               stall, redirect;
  logic               ifid_load_mem, ifid_load_skid, ifid_bubble;
  logic               skid_load, skid_clear, drop_capture;
  logic [PC_W-1:0]    skid_pc;
  logic [INSTR_W-1:0] skid_instr;
  logic               skid_full;

  assign stall    = prevent_update_pc | prevent_update_reg_IF_ID;
  assign redirect = branch_taken | jump;
  // EX-stage branch is older than the ID-stage jump, so it takes precedence.
  assign redirect_pc = branch_taken ? {branch_target[PC_W-1:2], 2'b00}
                                    : {jump_target[PC_W-1:2], 2'b00};
  assign pc_next  = pc_q + PC_W'(PC_INCR);

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    ifid_load_mem  = 1'b0;
    ifid_load_skid = 1'b0;
    ifid_bubble    = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    drop_capture   = 1'b0;
    if (redirect) begin
      pc_d        = redirect_pc;
      ifid_bubble = 1'b1;
      skid_clear  = 1'b1;
      if (state_q == FETCH && !imem_ready) begin
        state_d      = DROP;
        drop_capture = 1'b1;
      end else if (state_q == DROP && !imem_ready) begin
        state_d = DROP;
      end else begin
        state_d = enable ? FETCH : IDLE;
      end
    end else begin
      case (state_q)
        IDLE: if (enable) state_d = FETCH;
        FETCH: begin
          if (imem_ready) begin
            if (stall) begin
              skid_load = 1'b1;
              state_d   = HOLD;
            end else begin
              ifid_load_mem = 1'b1;
              pc_d          = pc_next;
              state_d       = enable ? FETCH : IDLE;
            end
          end else if (!stall) begin
            ifid_bubble = 1'b1;
          end
        end
        HOLD: begin
          if (!stall) begin
            ifid_load_skid = 1'b1;
            skid_clear     = 1'b1;
            pc_d           = pc_next;
            state_d        = enable ? FETCH : IDLE;
          end
        end
        DROP: if (imem_ready) state_d = enable ? FETCH : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= IDLE;
      pc_q        <= PC_RESET;
      drop_addr_q <= PC_RESET;
      if_id_pc    <= '0;
      if_id_instr <= NOP_INSTR;
      if_id_valid <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (drop_capture) drop_addr_q <= pc_q;
      if (ifid_bubble) begin
        if_id_instr <= NOP_INSTR;
        if_id_valid <= 1'b0;
      end else if (ifid_load_mem) begin
        if_id_pc    <= pc_q;
        if_id_instr <= imem_rdata;
        if_id_valid <= 1'b1;
      end else if (ifid_load_skid) begin
        if_id_pc    <= skid_pc;
        if_id_instr <= skid_instr;
        if_id_valid <= 1'b1;
      end
    end
  end

  // DROP keeps the abandoned address on the bus until imem answers it.
  assign imem_req  = (state_q == FETCH) || (state_q == DROP);
  assign imem_addr = (state_q == DROP) ? drop_addr_q : pc_q;

  if_skid_buffer #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W)
  ) u_skid (
    .clk      (clk),
    .arst_n   (arst_n),
    .load     (skid_load),
    .clear    (skid_clear),
    .ld_pc    (pc_q),
    .ld_instr (imem_rdata),
    .pc       (skid_pc),
    .instr    (skid_instr),
    .full     (skid_full)
  );

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (stall && stall_cycles != '1) stall_cycles <= stall_cycles + 32'd1;
      if (redirect && flush_count != '1) flush_count <= flush_count + 32'd1;
    end
  end
`endif

  logic unused_skid_full;
  assign unused_skid_full = skid_full;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed scenarios plus random traffic against a transaction-level model.
module tb_if_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        enable = 1'b0, prevent_update_pc = 1'b0, prevent_update_reg_IF_ID = 1'b0;
  logic        branch_taken = 1'b0, jump = 1'b0, imem_ready = 1'b0;
  logic [31:0] branch_target = '0, jump_target = '0, imem_rdata = '0;
  logic        imem_req, if_id_valid, w_req, w_valid;
  logic [31:0] imem_addr, if_id_pc, if_id_instr, w_addr, w_pc, w_instr;
`ifdef IF_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_count, w_stall_cycles, w_flush_count;
  logic [31:0] m_sc, m_fc;
`endif

  always #5 clk = ~clk;

  if_fetch_stage u_dut (
    .clk(clk), .arst_n(arst_n), .enable(enable),
    .prevent_update_pc(prevent_update_pc), .prevent_update_reg_IF_ID(prevent_update_reg_IF_ID),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .if_id_pc(if_id_pc), .if_id_instr(if_id_instr), .if_id_valid(if_id_valid)
`ifdef IF_PERF_CNT_EN
    , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
  );

  if_fetch_stage #(.PC_RESET(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .arst_n(arst_n), .enable(enable),
    .prevent_update_pc(prevent_update_pc), .prevent_update_reg_IF_ID(prevent_update_reg_IF_ID),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .imem_req(w_req), .imem_addr(w_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .if_id_pc(w_pc), .if_id_instr(w_instr), .if_id_valid(w_valid)
`ifdef IF_PERF_CNT_EN
    , .stall_cycles(w_stall_cycles), .flush_count(w_flush_count)
`endif
  );

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  // Model: bus has a live request (m_busy), whose answer may be owed to an abandoned
  // address (m_stale); a response may be parked during a stall (m_parked).
  logic [31:0] m_pc, m_stale_addr, m_park_pc, m_park_instr, m_ifid_pc, m_ifid_instr;
  logic        m_busy, m_stale, m_parked, m_ifid_valid;

  function automatic void m_reset();
    m_pc = 32'h0; m_stale_addr = 32'h0; m_park_pc = '0; m_park_instr = '0;
    m_ifid_pc = '0; m_ifid_instr = NOP; m_ifid_valid = 1'b0;
    m_busy = 1'b0; m_stale = 1'b0; m_parked = 1'b0;
`ifdef IF_PERF_CNT_EN
    m_sc = '0; m_fc = '0;
`endif
  endfunction

  function automatic logic [31:0] m_addr();
    return m_stale ? m_stale_addr : m_pc;
  endfunction

  function automatic void m_step();
    logic        stall, redir;
    logic [31:0] tgt;
    stall = prevent_update_pc | prevent_update_reg_IF_ID;
    redir = branch_taken | jump;
    tgt   = branch_taken ? branch_target : jump_target;
    tgt   = tgt & 32'hFFFF_FFFC;
`ifdef IF_PERF_CNT_EN
    if (stall && m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
    if (redir && m_fc != 32'hFFFF_FFFF) m_fc = m_fc + 1;
`endif
    if (redir) begin
      if (m_busy && !imem_ready) begin
        if (!m_stale) begin m_stale = 1'b1; m_stale_addr = m_pc; end
      end else begin
        m_stale = 1'b0; m_busy = enable;
      end
      m_pc = tgt; m_ifid_instr = NOP; m_ifid_valid = 1'b0; m_parked = 1'b0;
    end else if (m_stale) begin
      if (imem_ready) begin m_stale = 1'b0; m_busy = enable; end
    end else if (m_busy) begin
      if (imem_ready && !stall) begin
        m_ifid_pc = m_pc; m_ifid_instr = imem_rdata; m_ifid_valid = 1'b1;
        m_pc = m_pc + 32'd4; m_busy = enable;
      end else if (imem_ready) begin
        m_parked = 1'b1; m_park_pc = m_pc; m_park_instr = imem_rdata; m_busy = 1'b0;
      end else if (!stall) begin
        m_ifid_instr = NOP; m_ifid_valid = 1'b0;
      end
    end else if (m_parked) begin
      if (!stall) begin
        m_ifid_pc = m_park_pc; m_ifid_instr = m_park_instr; m_ifid_valid = 1'b1;
        m_parked = 1'b0; m_pc = m_pc + 32'd4; m_busy = enable;
      end
    end else if (enable) begin
      m_busy = 1'b1;
    end
  endfunction

  task automatic check_all();
    chk("imem_req", 32'(imem_req), 32'(m_busy));
    chk("imem_addr", imem_addr, m_addr());
    chk("if_id_pc", if_id_pc, m_ifid_pc);
    chk("if_id_instr", if_id_instr, m_ifid_instr);
    chk("if_id_valid", 32'(if_id_valid), 32'(m_ifid_valid));
`ifdef IF_PERF_CNT_EN
    chk("stall_cycles", stall_cycles, m_sc);
    chk("flush_count", flush_count, m_fc);
`endif
  endtask

  task automatic cycle(input logic en, input logic s_pc, input logic s_ifid,
                       input logic bt, input logic [31:0] btg,
                       input logic j, input logic [31:0] jtg,
                       input logic rdy, input logic [31:0] rd);
    enable = en; prevent_update_pc = s_pc; prevent_update_reg_IF_ID = s_ifid;
    branch_taken = bt; branch_target = btg; jump = j; jump_target = jtg;
    imem_ready = rdy; imem_rdata = rd;
    @(posedge clk);
    m_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_req"}, 32'(imem_req), 32'h0);
    chk({tag, "_addr"}, imem_addr, 32'h0);
    chk({tag, "_pc"}, if_id_pc, 32'h0);
    chk({tag, "_instr"}, if_id_instr, NOP);
    chk({tag, "_valid"}, 32'(if_id_valid), 32'h0);
    chk({tag, "_wrap_addr"}, w_addr, 32'hFFFF_FFFC);
  endtask

  initial begin
    m_reset();
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    arst_n = 1'b1;

    // Streaming with imem always ready.
    for (int k = 0; k < 5; k++) begin
      cycle(1, 0, 0, 0, 0, 0, 0, 1, {16'hC0DE, m_addr()[15:0]});
      chk("stream_addr", imem_addr, 32'(k) * 32'd4);
      if (k >= 1) chk("stream_valid", 32'(if_id_valid), 32'h1);
      if (k == 0) chk("wrap_first_addr", w_addr, 32'hFFFF_FFFC);
      if (k == 1) chk("wrap_second_addr", w_addr, 32'h0000_0000);
    end

    // Three-cycle stall at PC 0x10 with the response already available.
    cycle(1, 1, 0, 0, 0, 0, 0, 1, 32'hAAAA_0010);
    chk("hold_req", 32'(imem_req), 32'h0);
    for (int k = 0; k < 2; k++) begin
      cycle(1, k[0], !k[0], 0, 0, 0, 0, 1, 32'h5555_5555);
      chk("hold_req2", 32'(imem_req), 32'h0);
      chk("hold_ifid_pc", if_id_pc, 32'h0000_000C);
    end
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    chk("release_pc", if_id_pc, 32'h0000_0010);
    chk("release_instr", if_id_instr, 32'hAAAA_0010);
    chk("release_addr", imem_addr, 32'h0000_0014);

    // Branch and jump together, also under stall: branch wins.
    cycle(1, 1, 0, 1, 32'h100, 1, 32'h200, 1, 32'h1111_1111);
    chk("both_addr", imem_addr, 32'h0000_0100);
    chk("both_valid", 32'(if_id_valid), 32'h0);
    chk("both_instr", if_id_instr, NOP);

    // Redirect while 0x20 pending: response discarded, then fetch at 0x40.
    cycle(1, 0, 0, 0, 0, 1, 32'h23, 1, 32'h2222_2222);
    chk("jmp_addr", imem_addr, 32'h0000_0020);
    cycle(1, 0, 0, 1, 32'h40, 0, 0, 0, 32'h0);
    chk("drop_addr", imem_addr, 32'h0000_0020);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    chk("drop_addr2", imem_addr, 32'h0000_0020);
    cycle(1, 0, 0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF);
    chk("after_drop_addr", imem_addr, 32'h0000_0040);
    chk("after_drop_instr", if_id_instr, NOP);

    // Two wait states without stall insert two bubbles.
    cycle(1, 0, 0, 0, 0, 0, 0, 1, 32'h1234_5678);
    chk("pre_bubble_valid", 32'(if_id_valid), 32'h1);
    for (int k = 0; k < 2; k++) begin
      cycle(1, 0, 0, 0, 0, 0, 0, 0, 32'h0);
      chk("bubble_valid", 32'(if_id_valid), 32'h0);
      chk("bubble_instr", if_id_instr, NOP);
    end

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      cycle($urandom_range(9, 0) != 0, $urandom_range(6, 0) == 0, $urandom_range(6, 0) == 0,
            $urandom_range(11, 0) == 0, $urandom, $urandom_range(11, 0) == 0, $urandom,
            $urandom_range(9, 0) < 7, $urandom);
    end

    // Asynchronous reset in the middle of a pending fetch.
    cycle(1, 0, 0, 1, 32'h80, 0, 0, 1, 32'h0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    chk("pre_rst_req", 32'(imem_req), 32'h1);
    #2 arst_n = 1'b0;
    #1 check_reset_values("midrst");
    m_reset();
    @(negedge clk);
    arst_n = 1'b1;
    for (int k = 0; k < 3; k++) cycle(1, 0, 0, 0, 0, 0, 0, 1, $urandom);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- PC register, instruction-memory request handshake and IF/ID pipeline register for the 5-stage core.
- Sits directly upstream of the ID-stage hazard detection logic. Consumes its prevent_update_pc / prevent_update_reg_IF_ID stall outputs and produces the IF/ID instruction that hazard detection and decode inspect.
- Applies branch/jump redirects with IF/ID flush (bubble insertion).

Parameters:
- PC_W, 32, program-counter and address width.
- INSTR_W, 32, instruction width.
- PC_RESET, 32'h0000_0000, PC value after reset.
- NOP_INSTR, 32'h0000_0013, bubble encoding loaded into IF/ID on flush or empty slot.

Ports:
- clk  in  1  core clock, rising edge.
- arst_n  in  1  asynchronous active-low reset.
- enable  in  1  fetch enable; low = stop issuing new requests.
- prevent_update_pc  in  1  hazard stall: hold PC.
- prevent_update_reg_IF_ID  in  1  hazard stall: hold IF/ID.
- branch_taken  in  1  EX-stage branch resolved taken.
- branch_target  in  PC_W  branch destination.
- jump  in  1  ID-stage jump.
- jump_target  in  PC_W  jump destination.
- imem_req  out  1  fetch request valid.
- imem_addr  out  PC_W  fetch address.
- imem_ready  in  1  imem_rdata valid; completes request this cycle.
- imem_rdata  in  INSTR_W  fetched instruction.
- if_id_pc  out  PC_W  PC of instruction in IF/ID.
- if_id_instr  out  INSTR_W  instruction in IF/ID.
- if_id_valid  out  1  IF/ID holds a real instruction (0 = bubble).

Behaviour:
- Reset (async, arst_n low):
  - pc_q = PC_RESET; state IDLE; imem_req = 0; imem_addr = PC_RESET.
  - if_id_instr = NOP_INSTR; if_id_pc = 0; if_id_valid = 0; skid buffer empty.
  - Reset mid-handshake abandons the request; imem must tolerate this.
- stall = prevent_update_pc OR prevent_update_reg_IF_ID. Either one freezes both PC and IF/ID.
- redirect = branch_taken OR jump. branch_taken wins over jump because the EX instruction is older. Target bits [1:0] are forced to 0. Redirect has priority over stall.
- States: IDLE, FETCH, HOLD, DROP.
- IDLE:
  - imem_req = 0.
  - enable=1 -> FETCH next cycle with imem_addr = pc_q.
- FETCH:
  - imem_req = 1; imem_addr = pc_q, stable until imem_ready.
  - imem_ready & !stall & !redirect: IF/ID <= {pc_q, imem_rdata, valid 1}; pc_q <= pc_q + 4; stay in FETCH (back-to-back, 1 instr/cycle). If enable=0, go to IDLE instead.
  - imem_ready & stall & !redirect: IF/ID held; response captured in skid buffer; pc_q held; -> HOLD.
  - !imem_ready & !stall: IF/ID <= bubble (NOP_INSTR, valid 0).
  - !imem_ready & stall: IF/ID held.
- HOLD:
  - imem_req = 0.
  - While stall: everything held.
  - On !stall: IF/ID <= skid; pc_q <= pc_q + 4; -> FETCH (or IDLE if enable=0).
- Redirect, any state:
  - pc_q <= target; IF/ID <= bubble; skid cleared.
  - From FETCH with imem_ready=0: the outstanding request stays on the bus; -> DROP.
  - Otherwise: -> FETCH (IDLE if enable=0).
- DROP:
  - imem_req = 1 with the old address until imem_ready.
  - The response is discarded; IF/ID stays bubble; then -> FETCH at the new pc_q.
  - A second redirect in DROP only updates pc_q.
- PC arithmetic is modulo 2^PC_W; 32'hFFFF_FFFC + 4 wraps to 0.
- A jump and a stall in the same cycle: the redirect is taken and the stall is ignored for IF.

Optional Feature:
- Macro IF_PERF_CNT_EN.
- When defined, adds two outputs:
  - stall_cycles (32 bits): counts cycles with stall=1.
  - flush_count (32 bits): counts redirects.
- Both counters reset to 0 and saturate at all-ones.
- When undefined, these ports and their logic do not exist.

Decomposition:
- Shared package pipeline_pkg:
  - NOP_INSTR constant and PC_INCR = 4.
  - fetch_state_t enum {IDLE, FETCH, HOLD, DROP}.
  - PC_W and INSTR_W defaults.
- One sub-module, if_skid_buffer: a single-entry {pc, instr} holding register with load, clear and full flag, instantiated once.

Test Plan:
- Reset release, enable=1, imem_ready always 1 -> imem_addr 0,4,8,...; if_id_instr follows imem_rdata one cycle later; if_id_valid=1 from cycle 2.
- Stall for 3 cycles while imem_ready=1 at PC 0x10 -> imem_req=0 during HOLD. After release: if_id_pc=0x10, then a new fetch at 0x14; no instruction lost or duplicated.
- branch_taken with target 0x100 and jump with 0x200 in the same cycle -> pc_q=0x100; IF/ID = NOP_INSTR with valid 0.
- Redirect to 0x40 while imem_ready=0 (addr 0x20 pending) -> imem_addr stays 0x20 until ready; that response is discarded; next request is 0x40.
- imem_ready low for 2 cycles with no stall -> two bubbles (valid 0, NOP 0x00000013) enter IF/ID.
- PC_RESET=32'hFFFF_FFFC -> second fetch address is 0x0000_0000; arst_n pulsed mid-FETCH -> all outputs at reset values immediately.
